// File: rtl/team_06_lcd_pkg.sv
// Shared constants, state encodings and byte-selection helpers for the LCD writer.
package team_06_lcd_pkg;

  localparam int unsigned CNT_W  = 18;
  localparam int unsigned ROW_W  = 128;
  localparam int unsigned IDX_W  = 4;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_LOAD,
    ST_ADDR1,
    ST_ROW1,
    ST_ADDR2,
    ST_ROW2,
    ST_IDLE
  } main_state_t;

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_SETUP,
    BT_PULSE,
    BT_HOLD
  } byte_state_t;

  // Init command sequence, in the order the panel expects it.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Character idx of a row; char 0 lives in the top byte.
  function automatic logic [7:0] row_char(input logic [ROW_W-1:0] row,
                                          input logic [IDX_W-1:0] idx);
    return row[{4'd15 - idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/team_06_lcd_writer_if.sv
// Parallel write-only HD44780 pin bundle.
interface team_06_lcd_writer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_en, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_data);
endinterface

// File: rtl/team_06_lcd_byte_tx.sv
// One LCD byte write: setup, enable pulse, then a hold wait sized for the command.
module team_06_lcd_byte_tx
  import team_06_lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYCLES = 5,
  parameter int unsigned CMD_CYCLES     = 400,
  parameter int unsigned CLEAR_CYCLES   = 16000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       ready_c,
  output logic       byte_done,
  team_06_lcd_writer_if.master lcd
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  byte_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] hold_last, hold_last_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic             en_q, en_d;
  logic             done_d;

  assign hold_last   = long_q ? CLEAR_LAST : CMD_LAST;
  assign hold_last_d = long_d ? CLEAR_LAST : CMD_LAST;

  // Accepting on the last hold cycle lets bytes run back to back.
  assign ready_c = (state == BT_IDLE) || ((state == BT_HOLD) && (cnt == hold_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BT_IDLE;
      cnt       <= '0;
      rs_q      <= 1'b0;
      data_q    <= '0;
      long_q    <= 1'b0;
      en_q      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      long_q    <= long_d;
      en_q      <= en_d;
      byte_done <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    en_d    = 1'b0;

    case (state)
      BT_IDLE: ;
      BT_SETUP: begin
        state_d = BT_PULSE;
        cnt_d   = '0;
        en_d    = 1'b1;
      end
      BT_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_d = BT_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          en_d  = 1'b1;
        end
      end
      BT_HOLD: begin
        if (cnt == hold_last) state_d = BT_IDLE;
        else                  cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = BT_IDLE;
    endcase

    if (ready_c && start) begin
      state_d = BT_SETUP;
      cnt_d   = '0;
      rs_d    = rs;
      data_d  = data;
      long_d  = long_wait;
    end

    // Registered done must already be high during the final hold cycle.
    done_d = (state_d == BT_HOLD) && (cnt_d == hold_last_d);
  end

  assign lcd.lcd_rs   = rs_q;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_en   = en_q;
  assign lcd.lcd_data = data_q;

endmodule

// File: rtl/team_06_lcd_writer.sv
// 16x2 LCD writer: power-up delay, init, then full-panel rewrite whenever the text changes.
module team_06_lcd_writer
  import team_06_lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 150000,
  parameter int unsigned E_PULSE_CYCLES = 5,
  parameter int unsigned CMD_CYCLES     = 400,
  parameter int unsigned CLEAR_CYCLES   = 16000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] row_1,
  input  logic [ROW_W-1:0] row_2,
  team_06_lcd_writer_if.master lcd,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(15);
  localparam logic [IDX_W-1:0] INIT_LAST    = IDX_W'(3);

  main_state_t      state, state_d;
  logic [CNT_W-1:0] pu_cnt, pu_cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             drain, drain_d;
  logic [ROW_W-1:0] shadow_1, shadow_1_d;
  logic [ROW_W-1:0] shadow_2, shadow_2_d;
  logic             busy_d, frame_done_d;

  logic             tx_start_c;
  logic             tx_rs_c;
  logic [7:0]       tx_data_c;
  logic             tx_long_c;
  logic             tx_ready_c;
  logic             tx_done;

  team_06_lcd_byte_tx #(
    .E_PULSE_CYCLES (E_PULSE_CYCLES),
    .CMD_CYCLES     (CMD_CYCLES),
    .CLEAR_CYCLES   (CLEAR_CYCLES)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (tx_start_c),
    .rs        (tx_rs_c),
    .data      (tx_data_c),
    .long_wait (tx_long_c),
    .ready_c   (tx_ready_c),
    .byte_done (tx_done),
    .lcd       (lcd)
  );

  // Byte the current state would send next.
  always_comb begin
    tx_rs_c   = 1'b0;
    tx_data_c = 8'h00;
    case (state)
      ST_INIT:  tx_data_c = init_cmd(idx[1:0]);
      ST_ADDR1: tx_data_c = LCD_LINE1;
      ST_ROW1: begin
        tx_rs_c   = 1'b1;
        tx_data_c = row_char(shadow_1, idx);
      end
      ST_ADDR2: tx_data_c = LCD_LINE2;
      ST_ROW2: begin
        tx_rs_c   = 1'b1;
        tx_data_c = row_char(shadow_2, idx);
      end
      default: ;
    endcase
    tx_long_c = !tx_rs_c && (tx_data_c == LCD_CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_POWERUP;
      pu_cnt     <= '0;
      idx        <= '0;
      drain      <= 1'b0;
      shadow_1   <= '0;
      shadow_2   <= '0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      pu_cnt     <= pu_cnt_d;
      idx        <= idx_d;
      drain      <= drain_d;
      shadow_1   <= shadow_1_d;
      shadow_2   <= shadow_2_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  // Sequencing advances when a byte is issued; drain waits out the final byte of a phase.
  always_comb begin
    state_d      = state;
    pu_cnt_d     = pu_cnt;
    idx_d        = idx;
    drain_d      = drain;
    shadow_1_d   = shadow_1;
    shadow_2_d   = shadow_2;
    frame_done_d = 1'b0;
    tx_start_c   = 1'b0;

    case (state)
      ST_POWERUP: begin
        if (pu_cnt == POWERUP_LAST) begin
          state_d  = ST_INIT;
          pu_cnt_d = '0;
          idx_d    = '0;
        end else begin
          pu_cnt_d = pu_cnt + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (drain) begin
          if (tx_done) begin
            drain_d = 1'b0;
            state_d = ST_LOAD;
          end
        end else if (tx_ready_c) begin
          tx_start_c = 1'b1;
          idx_d      = idx + IDX_W'(1);
          if (idx == INIT_LAST) drain_d = 1'b1;
        end
      end
      ST_LOAD: begin
        shadow_1_d = row_1;
        shadow_2_d = row_2;
        idx_d      = '0;
        state_d    = ST_ADDR1;
      end
      ST_ADDR1: begin
        if (tx_ready_c) begin
          tx_start_c = 1'b1;
          state_d    = ST_ROW1;
        end
      end
      ST_ROW1: begin
        if (tx_ready_c) begin
          tx_start_c = 1'b1;
          idx_d      = idx + IDX_W'(1);
          if (idx == IDX_LAST) state_d = ST_ADDR2;
        end
      end
      ST_ADDR2: begin
        if (tx_ready_c) begin
          tx_start_c = 1'b1;
          state_d    = ST_ROW2;
        end
      end
      ST_ROW2: begin
        if (drain) begin
          if (tx_done) begin
            drain_d      = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if (tx_ready_c) begin
          tx_start_c = 1'b1;
          idx_d      = idx + IDX_W'(1);
          if (idx == IDX_LAST) drain_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if ({row_1, row_2} != {shadow_1, shadow_2}) state_d = ST_LOAD;
      end
      default: state_d = ST_POWERUP;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_team_06_lcd_writer.sv
// Scoreboard bench for team_06_lcd_writer: expected strobes queued from a text-level model.
module tb_team_06_lcd_writer;

  localparam int POWERUP = 20;
  localparam int E_PULSE = 2;
  localparam int CMD     = 4;
  localparam int CLEAR   = 10;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    bit         exact;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] row_1, row_2;
  logic         busy, frame_done;

  team_06_lcd_writer_if lcd ();

  team_06_lcd_writer #(
    .POWERUP_CYCLES (POWERUP),
    .E_PULSE_CYCLES (E_PULSE),
    .CMD_CYCLES     (CMD),
    .CLEAR_CYCLES   (CLEAR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_1      (row_1),
    .row_2      (row_2),
    .lcd        (lcd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         n_pop    = 0;
  int         fd_count = 0;
  int         fd_exp   = 0;
  logic [7:0] m1[16];
  logic [7:0] m2[16];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic int hold_of(input exp_t e);
    return (!e.rs && e.data == 8'h01) ? CLEAR : CMD;
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] d, input bit exact);
    exp_t e;
    e.rs = rs; e.data = d; e.exact = exact;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, 1'b1);
    push_byte(1'b0, 8'h0C, 1'b1);
    push_byte(1'b0, 8'h06, 1'b1);
    push_byte(1'b0, 8'h01, 1'b0);
  endtask

  // A frame as the panel should see it: address, 16 chars, address, 16 chars.
  task automatic push_frame();
    push_byte(1'b0, 8'h80, 1'b1);
    for (int i = 0; i < 16; i++) push_byte(1'b1, m1[i], 1'b1);
    push_byte(1'b0, 8'hC0, 1'b1);
    for (int i = 0; i < 16; i++) push_byte(1'b1, m2[i], i != 15);
    fd_exp++;
  endtask

  task automatic apply_rows();
    for (int i = 0; i < 16; i++) begin
      row_1[8*(15-i) +: 8] = m1[i];
      row_2[8*(15-i) +: 8] = m2[i];
    end
  endtask

  task automatic randomize_rows();
    logic [7:0] old0;
    old0 = m1[0];
    for (int i = 0; i < 16; i++) begin
      m1[i] = 8'($urandom);
      m2[i] = 8'($urandom);
    end
    if (m1[0] == old0) m1[0] = ~old0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((sb.size() != 0 || fd_count != fd_exp) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frame_in_time", int'(c < budget), 1);
    check("frame_done_count", fd_count, fd_exp);
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (lcd.lcd_en || busy) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic powerup_quiet();
    int early = 0;
    repeat (POWERUP) begin
      @(negedge clk);
      if (lcd.lcd_en) early++;
    end
    check("powerup_en_low", early, 0);
  endtask

  // Monitor: pops one expectation per enable rise and checks strobe timing.
  initial begin : monitor
    logic       prev_en, prev_rs, prev_fd, valid, holding, gap_chk, hold_ok;
    logic [7:0] prev_data;
    int         high, low_run, hold_cnt, hold_req, gap_req;
    exp_t       cur;
    prev_en = 0; prev_rs = 0; prev_fd = 0; valid = 0; holding = 0; gap_chk = 0; hold_ok = 0;
    prev_data = '0; high = 0; low_run = 0; hold_cnt = 0; hold_req = 0; gap_req = 0;
    cur.rs = 0; cur.data = 0; cur.exact = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        valid = 0; holding = 0; gap_chk = 0; high = 0; prev_en = 0; prev_fd = 0;
        continue;
      end
      if (lcd.lcd_en && !prev_en) begin
        if (holding) check("hold_length", hold_cnt, hold_req);
        if (gap_chk) check("strobe_gap", low_run, gap_req);
        if (valid) check("setup_stable", int'({prev_rs, prev_data}), int'({lcd.lcd_rs, lcd.lcd_data}));
        check("busy_during_strobe", int'(busy), 1);
        if (sb.size() == 0) begin
          check("unexpected_strobe", int'({lcd.lcd_rs, lcd.lcd_data}), -1);
          cur.rs = lcd.lcd_rs; cur.data = lcd.lcd_data; cur.exact = 0;
        end else begin
          cur = sb.pop_front();
          check("strobe_byte", int'({lcd.lcd_rs, lcd.lcd_data}), int'({cur.rs, cur.data}));
        end
        n_pop++;
        high = 1; holding = 0; gap_chk = 0; low_run = 0;
      end else if (lcd.lcd_en) begin
        high++;
      end else if (prev_en) begin
        check("en_width", high, E_PULSE);
        hold_req = hold_of(cur);
        hold_cnt = 1;
        hold_ok  = ({lcd.lcd_rs, lcd.lcd_data} == {cur.rs, cur.data});
        holding  = 1;
        gap_chk  = cur.exact;
        gap_req  = hold_req + 1;
        low_run  = 1;
      end else begin
        low_run++;
        if (holding) begin
          hold_cnt++;
          if ({lcd.lcd_rs, lcd.lcd_data} != {cur.rs, cur.data}) hold_ok = 0;
          if (hold_cnt == hold_req) begin
            check("hold_stable", int'(hold_ok), 1);
            holding = 0;
          end
        end
      end
      if (frame_done) begin
        fd_count++;
        check("frame_done_width", int'(prev_fd), 0);
      end
      prev_en = lcd.lcd_en; prev_rs = lcd.lcd_rs; prev_data = lcd.lcd_data;
      prev_fd = frame_done; valid = 1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int base, c;
    rst = 1'b0;
    m1[0] = 8'h45; m1[1] = 8'h43; m1[2] = 8'h48; m1[3] = 8'h4F;
    for (int i = 4; i < 16; i++) m1[i] = 8'h20;
    for (int i = 0; i < 16; i++) m2[i] = 8'hFF;
    apply_rows();
    repeat (3) @(negedge clk);
    check("reset_en",         int'(lcd.lcd_en),   0);
    check("reset_rs",         int'(lcd.lcd_rs),   0);
    check("reset_rw",         int'(lcd.lcd_rw),   0);
    check("reset_data",       int'(lcd.lcd_data), 0);
    check("reset_frame_done", int'(frame_done),   0);
    check("reset_busy",       int'(busy),         1);

    // First frame with the ECHO / all-0xFF text.
    push_init();
    push_frame();
    rst = 1'b1;
    powerup_quiet();
    wait_drain(3000);
    @(negedge clk);
    check("busy_after_frame", int'(busy), 0);
    quiet_window("idle_no_activity", 500);

    // Random text changes while idle.
    for (int k = 0; k < 3; k++) begin
      randomize_rows();
      apply_rows();
      push_frame();
      wait_drain(3000);
      @(negedge clk);
      check("busy_after_random_frame", int'(busy), 0);
    end

    // Change row 2 char 7 while row 1 is being written.
    randomize_rows();
    apply_rows();
    push_frame();
    base = n_pop;
    c = 0;
    while (n_pop < base + 5 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("reach_row1", int'(c < 3000), 1);
    m2[7] = m2[7] ^ 8'hA5;
    apply_rows();
    push_frame();
    wait_drain(4000);
    quiet_window("idle_after_refresh", 100);

    // Reset while a row 2 character strobe is high.
    randomize_rows();
    apply_rows();
    push_frame();
    base = n_pop;
    c = 0;
    while (!(n_pop >= base + 21 && lcd.lcd_en) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("reach_row2_pulse", int'(c < 3000), 1);
    #1 rst = 1'b0;
    #1;
    check("abort_en_low",   int'(lcd.lcd_en), 0);
    check("abort_busy",     int'(busy),       1);
    check("abort_data_clr", int'(lcd.lcd_data), 0);
    sb.delete();
    fd_exp = fd_count;
    repeat (3) @(negedge clk);
    push_init();
    push_frame();
    rst = 1'b1;
    powerup_quiet();
    wait_drain(3000);
    quiet_window("idle_after_reinit", 50);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
